// File: rtl/rob_alloc_retire_ctrl_pkg.sv
// Shared reorder-buffer definitions: geometry, FSM encoding,
// retire width and completion pipe indices.
package rob_alloc_retire_ctrl_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int TAG_W     = 4;
   localparam int RET_W     = 4;
   localparam int RUN_W     = 3;
   localparam int N_PIPES   = 4;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Bit / slice index of each completion pipe; pipe1 is the MSB.
   typedef enum int {
      PIPE_BR   = 0,
      PIPE_LDST = 1,
      PIPE_ALU2 = 2,
      PIPE_ALU1 = 3
   } pipe_e;

endpackage

// File: rtl/rob_alloc_retire_ctrl_if.sv
// Dispatch, completion, flush and retire bundle of the ROB
// controller; master drives requests, slave is the controller.
interface rob_alloc_retire_ctrl_if #(
   parameter int TAG_W = rob_alloc_retire_ctrl_pkg::TAG_W
);
   logic [1:0]         alloc_req_in;
   logic [1:0]         alloc_grant_out;
   logic [2*TAG_W-1:0] alloc_tag_out;
   logic [3:0]         complete_valid_in;
   logic [4*TAG_W-1:0] complete_tag_in;
   logic               flush_in;
   logic [TAG_W-1:0]   flush_tag_in;
   logic               ldm_stall_in;
   logic               drain_req_in;
   logic [3:0]         retire_valid_out;
   logic [4*TAG_W-1:0] retire_tag_out;
   logic               rob_full_out;
   logic               rob_empty_out;
   logic               drain_done_out;
   logic [TAG_W:0]     free_count_out;

   modport master (
      output alloc_req_in, complete_valid_in,
      output complete_tag_in, flush_in,
      output flush_tag_in, ldm_stall_in,
      output drain_req_in,
      input  alloc_grant_out, alloc_tag_out,
      input  retire_valid_out, retire_tag_out,
      input  rob_full_out, rob_empty_out,
      input  drain_done_out, free_count_out
   );

   modport slave (
      input  alloc_req_in, complete_valid_in,
      input  complete_tag_in, flush_in,
      input  flush_tag_in, ldm_stall_in,
      input  drain_req_in,
      output alloc_grant_out, alloc_tag_out,
      output retire_valid_out, retire_tag_out,
      output rob_full_out, rob_empty_out,
      output drain_done_out, free_count_out
   );

endinterface

// File: rtl/rob_retire_scan.sv
// Head-relative run-length scan: counts consecutive retirable
// entries starting at head, capped at the retire width.
module rob_retire_scan #(
   parameter int ROB_DEPTH = rob_alloc_retire_ctrl_pkg::ROB_DEPTH,
   parameter int TAG_W     = rob_alloc_retire_ctrl_pkg::TAG_W
) (
   input  logic [ROB_DEPTH-1:0] ready_i,
   input  logic [TAG_W-1:0]     head_i,
   output logic [2:0]           run_len_o
);
   import rob_alloc_retire_ctrl_pkg::*;

   logic             stop;
   logic [TAG_W-1:0] idx;

   always_comb begin
      run_len_o = '0;
      stop      = 1'b0;
      idx       = '0;
      for (int k = 0; k < RET_W; k++) begin
         idx = head_i + TAG_W'(k);
         if (!stop && ready_i[idx])
            run_len_o = run_len_o + 3'd1;
         else
            stop = 1'b1;
      end
   end

endmodule

// File: rtl/rob_alloc_retire_ctrl.sv
// Reorder-buffer allocate/complete/retire control with
// mispeculation flush and drain-to-empty sequencing.
module rob_alloc_retire_ctrl #(
   parameter int ROB_DEPTH = rob_alloc_retire_ctrl_pkg::ROB_DEPTH,
   parameter int TAG_W     = rob_alloc_retire_ctrl_pkg::TAG_W
) (
   input logic                    clk_in,
   input logic                    reset_n_in,
   rob_alloc_retire_ctrl_if.slave bus
);
   import rob_alloc_retire_ctrl_pkg::*;

   localparam int CW = TAG_W + 1;

   state_e                 state_q, state_d;
   logic                   ret_drain_q, ret_drain_d;
   logic [TAG_W-1:0]       head_q, head_d;
   logic [TAG_W-1:0]       tail_q, tail_d;
   logic [CW-1:0]          count_q, count_d;
   logic [ROB_DEPTH-1:0]   valid_q, valid_d;
   logic [ROB_DEPTH-1:0]   done_q, done_d;
   logic [RET_W-1:0]       rvld_q, rvld_d;
   logic [RET_W*TAG_W-1:0] rtag_q, rtag_d;
   logic                   drain_done_q, drain_done_d;

   logic [CW-1:0]        free;
   logic [1:0]           grant;
   logic [1:0]           n_grant;
   logic [TAG_W-1:0]     tag1, tag0;
   logic                 flush_ok;
   logic [TAG_W-1:0]     new_tail, n_sq, sq_idx;
   logic [ROB_DEPTH-1:0] squash, ready;
   logic [RUN_W-1:0]     run_len, n_ret;
   logic [TAG_W-1:0]     idx, ctag;

   assign free = CW'(ROB_DEPTH) - count_q;

   always_comb begin
      grant = 2'b00;
      if (state_q == ST_RUN && !bus.flush_in &&
          !bus.drain_req_in && free != '0) begin
         unique case (bus.alloc_req_in)
            2'b11:   grant = (free == CW'(1)) ? 2'b10 : 2'b11;
            2'b10:   grant = 2'b10;
            2'b01:   grant = 2'b01;
            default: grant = 2'b00;
         endcase
      end
      n_grant = {1'b0, grant[1]} + {1'b0, grant[0]};
      tag1    = tail_q;
      tag0    = bus.alloc_req_in[1] ? tail_q + TAG_W'(1) : tail_q;
   end

   // Squash window is flush_tag+1 .. tail-1, walked from the new tail.
   always_comb begin
      flush_ok = bus.flush_in && valid_q[bus.flush_tag_in];
      new_tail = bus.flush_tag_in + TAG_W'(1);
      n_sq     = tail_q - new_tail;
      squash   = '0;
      sq_idx   = '0;
      if (flush_ok) begin
         for (int k = 0; k < ROB_DEPTH; k++) begin
            sq_idx = new_tail + TAG_W'(k);
            if (TAG_W'(k) < n_sq)
               squash[sq_idx] = 1'b1;
         end
      end
      ready = valid_q & done_q & ~squash;
   end

   rob_retire_scan #(
      .ROB_DEPTH (ROB_DEPTH),
      .TAG_W     (TAG_W)
   ) u_scan (
      .ready_i   (ready),
      .head_i    (head_q),
      .run_len_o (run_len)
   );

   always_comb begin
      n_ret = '0;
      if (state_q != ST_FLUSH && !bus.ldm_stall_in)
         n_ret = run_len;
      valid_d = valid_q & ~squash;
      done_d  = done_q;
      rvld_d  = '0;
      rtag_d  = '0;
      idx     = '0;
      ctag    = '0;
      for (int k = 0; k < RET_W; k++) begin
         idx = head_q + TAG_W'(k);
         if (RUN_W'(k) < n_ret) begin
            valid_d[idx] = 1'b0;
            rvld_d[RET_W-1-k] = 1'b1;
            rtag_d[(RET_W-1-k)*TAG_W +: TAG_W] = idx;
         end
      end
      for (int p = 0; p < N_PIPES; p++) begin
         ctag = bus.complete_tag_in[p*TAG_W +: TAG_W];
         if (bus.complete_valid_in[p] &&
             valid_q[ctag] && !squash[ctag])
            done_d[ctag] = 1'b1;
      end
      if (grant[1]) begin
         valid_d[tag1] = 1'b1;
         done_d[tag1]  = 1'b0;
      end
      if (grant[0]) begin
         valid_d[tag0] = 1'b1;
         done_d[tag0]  = 1'b0;
      end
      head_d = head_q + TAG_W'(n_ret);
      if (flush_ok) begin
         tail_d  = new_tail;
         count_d = count_q - CW'(n_sq) - CW'(n_ret);
      end else begin
         tail_d  = tail_q + TAG_W'(n_grant);
         count_d = count_q + CW'(n_grant) - CW'(n_ret);
      end
   end

   // A flush taken in DRAIN remembers to come back to DRAIN.
   always_comb begin
      state_d      = state_q;
      ret_drain_d  = ret_drain_q;
      drain_done_d = 1'b0;
      if (flush_ok) begin
         state_d = ST_FLUSH;
         if (state_q != ST_FLUSH)
            ret_drain_d = (state_q == ST_DRAIN);
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (bus.drain_req_in)
                  state_d = ST_DRAIN;
            end
            ST_FLUSH: begin
               state_d = ret_drain_q ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
               if (count_q == '0) begin
                  state_d      = ST_RUN;
                  drain_done_d = 1'b1;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q      <= ST_RUN;
         ret_drain_q  <= 1'b0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         valid_q      <= '0;
         done_q       <= '0;
         rvld_q       <= '0;
         rtag_q       <= '0;
         drain_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ret_drain_q  <= ret_drain_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
         rvld_q       <= rvld_d;
         rtag_q       <= rtag_d;
         drain_done_q <= drain_done_d;
      end
   end

   assign bus.alloc_grant_out  = grant;
   assign bus.alloc_tag_out    = {tag1, tag0};
   assign bus.free_count_out   = free;
   assign bus.rob_full_out     = (count_q == CW'(ROB_DEPTH));
   assign bus.rob_empty_out    = (count_q == '0);
   assign bus.retire_valid_out = rvld_q;
   assign bus.retire_tag_out   = rtag_q;
   assign bus.drain_done_out   = drain_done_q;

endmodule

// File: tb/tb_rob_alloc_retire_ctrl.sv
// Directed scenarios plus random traffic against a queue-based
// model of the reorder buffer.
module tb_rob_alloc_retire_ctrl;

   localparam int D = 16;
   localparam int W = 4;
   localparam int M_RUN = 0;
   localparam int M_FLUSH = 1;
   localparam int M_DRAIN = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rob_alloc_retire_ctrl_if #(.TAG_W(W)) bus ();

   rob_alloc_retire_ctrl #(
      .ROB_DEPTH (D),
      .TAG_W     (W)
   ) dut (
      .clk_in     (clk),
      .reset_n_in (rst_n),
      .bus        (bus)
   );

   int n_chk = 0;
   int n_bad = 0;

   int m_q[$];
   bit m_done[D];
   int m_head;
   int m_mode;
   bit m_ret;
   logic [3:0] e_rv;
   logic [15:0] e_rt;
   bit e_dd;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      bus.alloc_req_in      = '0;
      bus.complete_valid_in = '0;
      bus.complete_tag_in   = '0;
      bus.flush_in          = 1'b0;
      bus.flush_tag_in      = '0;
      bus.ldm_stall_in      = 1'b0;
      bus.drain_req_in      = 1'b0;
   endtask

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < D; i++) m_done[i] = 1'b0;
      m_head = 0;
      m_mode = M_RUN;
      m_ret  = 1'b0;
      e_rv   = '0;
      e_rt   = '0;
      e_dd   = 1'b0;
   endtask

   function automatic logic [1:0] m_grant();
      int fr;
      fr = D - m_q.size();
      if (m_mode != M_RUN || bus.flush_in || bus.drain_req_in)
         return 2'b00;
      case (bus.alloc_req_in)
         2'b11:   return (fr >= 2) ? 2'b11 : (fr == 1) ? 2'b10 : 2'b00;
         2'b10:   return (fr >= 1) ? 2'b10 : 2'b00;
         2'b01:   return (fr >= 1) ? 2'b01 : 2'b00;
         default: return 2'b00;
      endcase
   endfunction

   task automatic check_outs();
      logic [1:0] g;
      int tail;
      g = m_grant();
      tail = (m_head + m_q.size()) % D;
      chk("grant", bus.alloc_grant_out, g);
      if (g[1]) chk("tag1", bus.alloc_tag_out[7:4], tail);
      if (g[0]) chk("tag0", bus.alloc_tag_out[3:0],
                    g[1] ? (tail + 1) % D : tail);
      chk("free", bus.free_count_out, D - m_q.size());
      chk("full", bus.rob_full_out, m_q.size() == D);
      chk("empty", bus.rob_empty_out, m_q.size() == 0);
      chk("ret_v", bus.retire_valid_out, e_rv);
      chk("ret_t", bus.retire_tag_out, e_rt);
      chk("drain_done", bus.drain_done_out, e_dd);
   endtask

   task automatic model_step();
      int sz0, pos, keep, n, tail, t;
      bit legal;
      logic [1:0] g;
      sz0 = m_q.size();
      g = m_grant();
      tail = (m_head + sz0) % D;
      pos = -1;
      for (int i = 0; i < sz0; i++)
         if (m_q[i] == int'(bus.flush_tag_in)) pos = i;
      legal = bus.flush_in && pos >= 0;
      keep = legal ? pos + 1 : sz0;
      n = 0;
      if (m_mode != M_FLUSH && !bus.ldm_stall_in)
         while (n < 4 && n < keep && m_done[m_q[n]]) n++;
      for (int p = 0; p < 4; p++) begin
         if (bus.complete_valid_in[p]) begin
            t = int'(bus.complete_tag_in[p*4 +: 4]);
            for (int j = 0; j < keep; j++)
               if (m_q[j] == t) m_done[t] = 1'b1;
         end
      end
      e_rv = '0;
      e_rt = '0;
      for (int k = 0; k < n; k++) begin
         e_rv[3-k] = 1'b1;
         e_rt[(3-k)*4 +: 4] = 4'(m_q[k]);
      end
      e_dd = 1'b0;
      if (legal) begin
         if (m_mode != M_FLUSH) m_ret = (m_mode == M_DRAIN);
         m_mode = M_FLUSH;
      end else if (m_mode == M_FLUSH) begin
         m_mode = m_ret ? M_DRAIN : M_RUN;
      end else if (m_mode == M_RUN && bus.drain_req_in) begin
         m_mode = M_DRAIN;
      end else if (m_mode == M_DRAIN && sz0 == 0) begin
         m_mode = M_RUN;
         e_dd = 1'b1;
      end
      while (m_q.size() > keep) void'(m_q.pop_back());
      for (int k = 0; k < n; k++) void'(m_q.pop_front());
      m_head = (m_head + n) % D;
      if (g[1]) begin
         m_q.push_back(tail);
         m_done[tail] = 1'b0;
         tail = (tail + 1) % D;
      end
      if (g[0]) begin
         m_q.push_back(tail);
         m_done[tail] = 1'b0;
      end
   endtask

   task automatic cyc();
      #1;
      check_outs();
      model_step();
      @(negedge clk);
      clr();
   endtask

   // Reset is asserted between edges to exercise the async path.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_empty", bus.rob_empty_out, 1);
      chk("rst_full", bus.rob_full_out, 0);
      chk("rst_free", bus.free_count_out, 16);
      chk("rst_ret_v", bus.retire_valid_out, 0);
      chk("rst_ret_t", bus.retire_tag_out, 0);
      chk("rst_dd", bus.drain_done_out, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      clr();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen, hold, t;
      logic [3:0] cv;
      logic [15:0] ct;
      clr();
      model_reset();
      @(negedge clk);
      do_reset();

      // Fill in pairs, then overflow request.
      repeat (8) begin
         bus.alloc_req_in = 2'b11;
         cyc();
      end
      chk("s1_full", bus.rob_full_out, 1);
      bus.alloc_req_in = 2'b11;
      #1 chk("s1_nogrant", bus.alloc_grant_out, 0);
      cyc();

      // Four completions retire together.
      bus.complete_valid_in = 4'hF;
      bus.complete_tag_in = 16'h0123;
      cyc();
      cyc();
      chk("s2_ret_v", bus.retire_valid_out, 4'hF);
      chk("s2_ret_t", bus.retire_tag_out, 16'h0123);
      chk("s2_free", bus.free_count_out, 4);

      // Single free slot and tail wrap.
      do_reset();
      repeat (7) begin
         bus.alloc_req_in = 2'b11;
         cyc();
      end
      bus.alloc_req_in = 2'b10;
      cyc();
      bus.alloc_req_in = 2'b11;
      #1 chk("s3_grant", bus.alloc_grant_out, 2'b10);
      chk("s3_tag15", bus.alloc_tag_out[7:4], 15);
      cyc();
      bus.complete_valid_in = 4'hF;
      bus.complete_tag_in = 16'h0123;
      cyc();
      cyc();
      bus.alloc_req_in = 2'b01;
      #1 chk("s3_wrap", bus.alloc_tag_out[3:0], 0);
      cyc();

      // Flush at tag 6 with 4..9 live.
      do_reset();
      repeat (5) begin
         bus.alloc_req_in = 2'b11;
         cyc();
      end
      bus.complete_valid_in = 4'hF;
      bus.complete_tag_in = 16'h0123;
      cyc();
      cyc();
      bus.flush_in = 1'b1;
      bus.flush_tag_in = 4'd6;
      bus.alloc_req_in = 2'b11;
      #1 chk("s4_fl_grant", bus.alloc_grant_out, 0);
      cyc();
      bus.alloc_req_in = 2'b11;
      #1 chk("s4_st_grant", bus.alloc_grant_out, 0);
      chk("s4_free", bus.free_count_out, 13);
      cyc();
      bus.alloc_req_in = 2'b01;
      #1 chk("s4_tag7", bus.alloc_tag_out[3:0], 7);
      cyc();
      bus.flush_in = 1'b1;
      bus.flush_tag_in = 4'd12;
      bus.alloc_req_in = 2'b01;
      cyc();

      // Retire stall with head complete.
      bus.complete_valid_in = 4'b1000;
      bus.complete_tag_in = 16'h4000;
      bus.ldm_stall_in = 1'b1;
      cyc();
      repeat (3) begin
         bus.ldm_stall_in = 1'b1;
         cyc();
      end
      chk("s5_stall", bus.retire_valid_out, 0);
      cyc();
      chk("s5_ret_v", bus.retire_valid_out, 4'b1000);
      chk("s5_ret_t", bus.retire_tag_out[15:12], 4);

      // Drain with three live entries.
      do_reset();
      bus.alloc_req_in = 2'b11;
      cyc();
      bus.alloc_req_in = 2'b10;
      cyc();
      bus.drain_req_in = 1'b1;
      bus.alloc_req_in = 2'b11;
      #1 chk("s6_nogrant", bus.alloc_grant_out, 0);
      cyc();
      bus.drain_req_in = 1'b1;
      bus.alloc_req_in = 2'b11;
      bus.complete_valid_in = 4'b1110;
      bus.complete_tag_in = 16'h0120;
      cyc();
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         bus.drain_req_in = 1'b1;
         bus.alloc_req_in = 2'b11;
         cyc();
         if (bus.drain_done_out) seen = 1;
      end
      chk("s6_drain_done", seen, 1);
      bus.alloc_req_in = 2'b11;
      #1 chk("s6_run_grant", bus.alloc_grant_out, 2'b11);
      cyc();

      // Reset mid-operation.
      repeat (3) begin
         bus.alloc_req_in = 2'b11;
         cyc();
      end
      do_reset();
      bus.alloc_req_in = 2'b01;
      #1 chk("s7_tag0", bus.alloc_tag_out[3:0], 0);
      cyc();

      // Random traffic.
      hold = 0;
      repeat (600) begin
         bus.alloc_req_in = 2'($urandom_range(0, 3));
         cv = '0;
         ct = '0;
         for (int p = 0; p < 4; p++) begin
            if ($urandom_range(0, 2) == 0 && m_q.size() > 0) begin
               cv[p] = 1'b1;
               t = m_q[$urandom_range(0, m_q.size() - 1)];
               ct[p*4 +: 4] = 4'(t);
            end else if ($urandom_range(0, 9) == 0) begin
               cv[p] = 1'b1;
               ct[p*4 +: 4] = 4'($urandom_range(0, 15));
            end
         end
         bus.complete_valid_in = cv;
         bus.complete_tag_in = ct;
         bus.ldm_stall_in = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 24) == 0) begin
            bus.flush_in = 1'b1;
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
               t = m_q[$urandom_range(0, m_q.size() - 1)];
            else
               t = $urandom_range(0, 15);
            bus.flush_tag_in = 4'(t);
         end
         if (hold > 0) begin
            bus.drain_req_in = 1'b1;
            hold--;
         end else if ($urandom_range(0, 59) == 0) begin
            hold = $urandom_range(5, 20);
         end
         cyc();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
